// File: rtl/dram_arbiter.sv
// dram_arbiter: shares the single-port data RAM between the stage-three CPU
// port and the block-transfer DMA engine. The CPU has priority. The DMA
// engine runs bursts through an IDLE/BURST/DONE state machine.
// Optional build macro ARB_STARVE_GUARD_EN adds a starvation guard. With the
// guard, the DMA is forced a slot after STARVE_MAX consecutive CPU wins
// during a burst.
//
// Handshake semantics:
//   cpu_req / cpu_stall : an access is taken in any cycle where cpu_req=1 and
//                         cpu_stall=0; otherwise the pipeline holds.
//   dma_wdata / dma_wready : the beat is consumed in a cycle where
//                         dma_wready=1; the source advances after that edge.
//   cpu_rvalid / dma_rvalid : single-cycle pulses one cycle after a read
//                         grant. There is no back-pressure on read returns.
module dram_arbiter #(
    parameter int D_WIDTH = 8,
    parameter int A_WIDTH = 8
`ifdef ARB_STARVE_GUARD_EN
    ,
    parameter int STARVE_MAX = 3
`endif
) (
    input  logic               g_clk,
    input  logic               g_clr,
    input  logic               cpu_req,
    input  logic               cpu_we,
    input  logic [A_WIDTH-1:0] cpu_addr,
    input  logic [D_WIDTH-1:0] cpu_wdata,
    output logic               cpu_stall,
    output logic [D_WIDTH-1:0] cpu_rdata,
    output logic               cpu_rvalid,
    input  logic               dma_start,
    input  logic               dma_we,
    input  logic [A_WIDTH-1:0] dma_base,
    input  logic [A_WIDTH-1:0] dma_len,
    input  logic [D_WIDTH-1:0] dma_wdata,
    output logic               dma_wready,
    output logic [D_WIDTH-1:0] dma_rdata,
    output logic               dma_rvalid,
    output logic               dma_busy,
    output logic               dma_done,
    output logic [A_WIDTH-1:0] ram_addr,
    output logic               ram_we,
    output logic               ram_re,
    output logic [D_WIDTH-1:0] ram_wdata,
    input  logic [D_WIDTH-1:0] ram_rdata,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state, state_nx;
    logic [A_WIDTH-1:0] base_q, len_q, beat_q;
    logic               we_q;
    logic               cpu_grant, dma_grant;
    logic               starve_ok;
    logic               rd_pend_q, rd_owner_q;   // owner: 1 = DMA, 0 = CPU
    logic [D_WIDTH-1:0] cpu_rdata_q, dma_rdata_q;
    logic               dma_done_q;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_MAX + 1);
    logic [SW-1:0] starve_q;

    assign starve_ok = (starve_q < SW'(STARVE_MAX));

    // Count consecutive CPU wins inside a burst; any DMA grant resets it.
    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            starve_q <= '0;
        end else if (state == IDLE && dma_start) begin
            starve_q <= '0;
        end else if (dma_grant) begin
            starve_q <= '0;
        end else if (state == BURST && cpu_grant) begin
            starve_q <= starve_q + 1'b1;
        end
    end
`else
    // Strict CPU priority: the CPU may hold the RAM for the whole burst.
    assign starve_ok = 1'b1;
`endif

    // Per-cycle arbitration. Outside BURST the CPU owns the RAM. No grant is
    // issued while the clear is held.
    always_comb begin
        cpu_grant = 1'b0;
        dma_grant = 1'b0;
        if (!g_clr) begin
            if (state == BURST) begin
                if (cpu_req && starve_ok) begin
                    cpu_grant = 1'b1;
                end else begin
                    dma_grant = 1'b1;
                end
            end else begin
                cpu_grant = cpu_req;
            end
        end
    end

    // State register.
    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic. The burst ends when beat number len is granted.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (dma_start) state_nx = BURST;
            BURST:   if (dma_grant && beat_q == len_q) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Burst descriptor capture and beat counter.
    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            base_q <= '0;
            len_q  <= '0;
            we_q   <= 1'b0;
            beat_q <= '0;
        end else if (state == IDLE && dma_start) begin
            base_q <= dma_base;
            len_q  <= dma_len;
            we_q   <= dma_we;
            beat_q <= '0;
        end else if (dma_grant) begin
            beat_q <= beat_q + 1'b1;
        end
    end

    // RAM strobes. Without a grant, the address and data follow the CPU port.
    always_comb begin
        ram_addr   = cpu_addr;
        ram_wdata  = cpu_wdata;
        ram_we     = cpu_grant & cpu_we;
        ram_re     = cpu_grant & ~cpu_we;
        dma_wready = 1'b0;
        if (dma_grant) begin
            ram_addr   = base_q + beat_q;
            ram_we     = we_q;
            ram_re     = ~we_q;
            dma_wready = we_q;
            if (we_q) begin
                ram_wdata = dma_wdata;
            end
        end
        cpu_stall = cpu_req & ~cpu_grant;
    end

    // Read owner tag, registered alongside ram_re. A clear drops any read
    // still in flight.
    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= 1'b0;
        end else begin
            rd_pend_q  <= ram_re;
            rd_owner_q <= dma_grant;
        end
    end

    assign cpu_rvalid = rd_pend_q & ~rd_owner_q;
    assign dma_rvalid = rd_pend_q & rd_owner_q;

    // Hold the last returned word so the read data stays stable between reads.
    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
        end else begin
            if (cpu_rvalid) cpu_rdata_q <= ram_rdata;
            if (dma_rvalid) dma_rdata_q <= ram_rdata;
        end
    end

    // The RAM returns data in the cycle after the grant. The data is
    // forwarded in that cycle so the grant-to-rvalid latency is one cycle.
    assign cpu_rdata = cpu_rvalid ? ram_rdata : cpu_rdata_q;
    assign dma_rdata = dma_rvalid ? ram_rdata : dma_rdata_q;

    // One-cycle done pulse while in DONE.
    always_ff @(posedge g_clk) begin
        if (g_clr) begin
            dma_done_q <= 1'b0;
        end else begin
            dma_done_q <= (state == BURST) && (state_nx == DONE);
        end
    end

    assign dma_done  = dma_done_q;
    assign dma_busy  = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: directed scenarios followed by a randomized phase. The
// bench checks the DUT against a reference model of the arbitration rules.
// The model keeps its own memory image and a queue of expected DMA read data.
module tb_dram_arbiter;

    localparam int SMAX = 3;

    // ---------------- clock / reset ----------------
    logic       g_clk = 1'b0;
    logic       g_clr;
    always #5 g_clk = ~g_clk;

    logic       cpu_req, cpu_we, cpu_stall, cpu_rvalid;
    logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic       dma_start, dma_we, dma_wready, dma_rvalid, dma_busy, dma_done;
    logic [7:0] dma_base, dma_len, dma_wdata, dma_rdata;
    logic [7:0] ram_addr, ram_wdata, ram_rdata;
    logic       ram_we, ram_re;
    logic [1:0] dbg_state;

    dram_arbiter dut (
        .g_clk(g_clk), .g_clr(g_clr),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .dma_start(dma_start), .dma_we(dma_we), .dma_base(dma_base), .dma_len(dma_len),
        .dma_wdata(dma_wdata), .dma_wready(dma_wready), .dma_rdata(dma_rdata),
        .dma_rvalid(dma_rvalid), .dma_busy(dma_busy), .dma_done(dma_done),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_re(ram_re), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .dbg_state(dbg_state)
    );

    // Environment RAM: synchronous read, data valid the cycle after ram_re.
    logic [7:0] env_mem [256];
    always @(posedge g_clk) begin
        if (ram_re) ram_rdata <= env_mem[ram_addr];
        if (ram_we) env_mem[ram_addr] = ram_wdata;
    end

    // ---------------- reference model ----------------
    int         total, bad;
    int         wready_cnt, done_cnt, drv_cnt, coinc_cnt, stall_cnt;
    logic [7:0] mdl_mem [256];
    logic [7:0] exp_q [$];
    int         m_mode;     // 0 idle, 1 burst, 2 done
    int         m_beat, m_starve;
    logic [7:0] m_base, m_len;
    logic       m_we;
    logic       exp_cpu_rv, exp_dma_rv;
    logic [7:0] exp_cpu_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit starve_ok();
`ifdef ARB_STARVE_GUARD_EN
        return m_starve < SMAX;
`else
        return 1'b1;
`endif
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle_in();
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        dma_start = 0; dma_we = 0; dma_base = 0; dma_len = 0; dma_wdata = 0;
    endtask

    // One clock: check outputs mid-cycle, then advance the model at the edge.
    task automatic step();
        bit         cw, dw;
        logic [7:0] da, ed;
        #1;
        cw = cpu_req && (m_mode != 1 || starve_ok());
        dw = (m_mode == 1) && !cw;
        da = 8'(m_base + 8'(m_beat));
        chk("cpu_stall", cpu_stall, cpu_req && !cw);
        chk("ram_we", ram_we, dw ? m_we : (cw && cpu_we));
        chk("ram_re", ram_re, dw ? !m_we : (cw && !cpu_we));
        if (dw) chk("ram_addr_dma", ram_addr, da);
        else if (cw) chk("ram_addr_cpu", ram_addr, cpu_addr);
        if (dw && m_we) chk("ram_wdata_dma", ram_wdata, dma_wdata);
        else if (cw && cpu_we) chk("ram_wdata_cpu", ram_wdata, cpu_wdata);
        chk("dma_wready", dma_wready, dw && m_we);
        chk("dma_busy", dma_busy, m_mode != 0);
        chk("dma_done", dma_done, m_mode == 2);
        chk("cpu_rvalid", cpu_rvalid, exp_cpu_rv);
        if (exp_cpu_rv) chk("cpu_rdata", cpu_rdata, exp_cpu_rd);
        chk("dma_rvalid", dma_rvalid, exp_dma_rv);
        if (dma_rvalid) begin
            if (exp_q.size() == 0) chk("dma_rdata_unexpected", dma_rvalid, 0);
            else begin
                ed = exp_q.pop_front();
                chk("dma_rdata", dma_rdata, ed);
            end
        end
        if (dma_wready) wready_cnt++;
        if (dma_done) done_cnt++;
        if (dma_rvalid) drv_cnt++;
        if (dma_rvalid && dma_done) coinc_cnt++;
        if (cpu_stall) stall_cnt++;
        @(posedge g_clk);
        exp_cpu_rv = cw && !cpu_we;
        exp_cpu_rd = mdl_mem[cpu_addr];
        exp_dma_rv = dw && !m_we;
        if (dw && !m_we) exp_q.push_back(mdl_mem[da]);
        if (cw && cpu_we) mdl_mem[cpu_addr] = cpu_wdata;
        if (dw && m_we) mdl_mem[da] = dma_wdata;
        case (m_mode)
            0: if (dma_start) begin
                   m_base = dma_base; m_len = dma_len; m_we = dma_we;
                   m_beat = 0; m_starve = 0; m_mode = 1;
               end
            1: if (dw) begin
                   if (m_beat == int'(m_len)) m_mode = 2;
                   m_beat++; m_starve = 0;
               end else m_starve++;
            default: m_mode = 0;
        endcase
        @(negedge g_clk);
    endtask

    task automatic do_reset();
        g_clr = 1; cpu_req = 0; dma_start = 0;
        @(posedge g_clk);
        m_mode = 0; m_beat = 0; m_starve = 0;
        exp_cpu_rv = 0; exp_dma_rv = 0; exp_q.delete();
        @(negedge g_clk);
        g_clr = 0;
    endtask

    task automatic reset_checks();
        #1;
        chk("rst_busy", dma_busy, 0);
        chk("rst_done", dma_done, 0);
        chk("rst_cpu_rvalid", cpu_rvalid, 0);
        chk("rst_dma_rvalid", dma_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_dma_rdata", dma_rdata, 0);
    endtask

    task automatic run_idle(input int maxc);
        int n = 0;
        while (m_mode != 0 && n < maxc) begin
            step();
            n++;
        end
        chk("burst_timeout", dma_busy, 0);
    endtask

    task automatic clr_cnt();
        wready_cnt = 0; done_cnt = 0; drv_cnt = 0; coinc_cnt = 0; stall_cnt = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] v;
        total = 0; bad = 0; clr_cnt();
        m_mode = 0; m_beat = 0; m_starve = 0; m_base = 0; m_len = 0; m_we = 0;
        exp_cpu_rv = 0; exp_dma_rv = 0; exp_cpu_rd = 0;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            env_mem[i] = v;
            mdl_mem[i] = v;
        end
        idle_in();
        g_clr = 0;
        @(negedge g_clk);
        do_reset();
        reset_checks();

        // DMA write FE..01 with wrap, then a CPU read of 00.
        clr_cnt();
        dma_start = 1; dma_we = 1; dma_base = 8'hFE; dma_len = 8'd3;
        step();
        dma_start = 0;
        for (int i = 0; i < 4; i++) begin
            dma_wdata = 8'hA0 + 8'(i);
            step();
        end
        step();
        step();
        chk("wr_wready_cycles", wready_cnt, 4);
        chk("wr_done_pulses", done_cnt, 1);
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h00;
        step();
        cpu_req = 0;
        #1;
        chk("cpu_read_wrapped_rvalid", cpu_rvalid, 1);
        chk("cpu_read_wrapped_data", cpu_rdata, 8'hA2);
        step();

        // DMA read 10..11 with an idle CPU.
        clr_cnt();
        dma_start = 1; dma_we = 0; dma_base = 8'h10; dma_len = 8'd1;
        step();
        dma_start = 0;
        run_idle(20);
        chk("rd_rvalid_pulses", drv_cnt, 2);
        chk("rd_last_with_done", coinc_cnt, 1);

        // CPU priority: two CPU cycles, then the single DMA beat.
        clr_cnt();
        dma_start = 1; dma_we = 0; dma_base = 8'h30; dma_len = 8'd0;
        step();
        dma_start = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 8'h31; cpu_wdata = 8'h5A;
        step();
        cpu_we = 0;
        step();
        cpu_req = 0;
        run_idle(20);
        chk("prio_stalls", stall_cnt, 0);

        // Continuous cpu_req during a two-beat burst.
        clr_cnt();
        dma_start = 1; dma_we = 1; dma_base = 8'h50; dma_len = 8'd1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 8'h60;
        step();
        dma_start = 0;
        for (int i = 0; i < 12; i++) begin
            dma_wdata = 8'($urandom);
            step();
        end
`ifdef ARB_STARVE_GUARD_EN
        chk("guard_stalls", stall_cnt, 2);
        chk("guard_done", done_cnt, 1);
`else
        chk("noguard_stalls", stall_cnt, 0);
        chk("noguard_busy", dma_busy, 1);
`endif
        cpu_req = 0;
        run_idle(20);

        // A second dma_start during a burst is ignored.
        dma_start = 1; dma_we = 0; dma_base = 8'h40; dma_len = 8'd2;
        step();
        dma_base = 8'h80;
        step();
        step();
        dma_start = 0;
        run_idle(20);

        // Clear mid-burst with a read in flight.
        clr_cnt();
        dma_start = 1; dma_we = 0; dma_base = 8'h20; dma_len = 8'd3;
        step();
        dma_start = 0;
        step();
        do_reset();
        reset_checks();
        for (int i = 0; i < 5; i++) step();
        chk("abort_no_done", done_cnt, 0);
        dma_start = 1; dma_we = 0; dma_base = 8'h24; dma_len = 8'd1;
        step();
        dma_start = 0;
        #1;
        chk("restart_busy", dma_busy, 1);
        run_idle(20);
        chk("restart_done", done_cnt, 1);

        // Randomized traffic with occasional clears.
        for (int i = 0; i < 2000; i++) begin
            cpu_req   = ($urandom_range(0, 99) < 60);
            cpu_we    = 1'($urandom);
            cpu_addr  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
            cpu_wdata = 8'($urandom);
            dma_start = ($urandom_range(0, 9) == 0);
            dma_we    = 1'($urandom);
            dma_base  = 8'($urandom_range(0, 15)) + 8'($urandom_range(0, 1) * 240);
            dma_len   = 8'($urandom_range(0, 7));
            dma_wdata = 8'($urandom);
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
                reset_checks();
            end else begin
                step();
            end
        end
        idle_in();
        run_idle(600);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- Shares the single-port 256x8 data RAM between two requesters.
- Requester 1 is pipeline stage three (CPU port). Requester 2 is a block-transfer DMA engine (preload/dump port).
- The CPU port has priority. A starvation guard forces DMA progress.
- Sits between the stage-three address/data path and the D_RAM instance, and owns all RAM strobes.

Parameters:
- D_WIDTH, 8, RAM data width
- A_WIDTH, 8, RAM address width; addresses wrap modulo 2^A_WIDTH
- STARVE_MAX, 3, consecutive DMA-denied beats before DMA is forced a slot (only with guard macro)

Ports:
- g_clk in 1: clock, rising edge
- g_clr in 1: global clear, synchronous, active-high
- cpu_req in 1: CPU access request this cycle
- cpu_we in 1: 1 = write, 0 = read
- cpu_addr in A_WIDTH: CPU address
- cpu_wdata in D_WIDTH: CPU write data
- cpu_stall out 1: request not granted this cycle; the pipeline must hold
- cpu_rdata out D_WIDTH: CPU read data
- cpu_rvalid out 1: cpu_rdata valid
- dma_start in 1: start burst (sampled only in IDLE)
- dma_we in 1: burst direction, 1 = write to RAM
- dma_base in A_WIDTH: burst start address
- dma_len in A_WIDTH: beats minus 1 (0 = 1 beat, 255 = 256 beats)
- dma_wdata in D_WIDTH: current write beat data
- dma_wready out 1: dma_wdata consumed this cycle; the source advances
- dma_rdata out D_WIDTH: DMA read data
- dma_rvalid out 1: dma_rdata valid
- dma_busy out 1: high in BURST and DONE
- dma_done out 1: one-cycle pulse at burst end
- ram_addr out A_WIDTH, ram_we out 1, ram_re out 1, ram_wdata out D_WIDTH: RAM strobes
- ram_rdata in D_WIDTH: RAM read data, valid the cycle after ram_re

Behaviour:
- Reset: one clock with g_clr high forces IDLE.
  - Registered outputs cleared: cpu_rvalid, dma_rvalid, dma_done, cpu_rdata, dma_rdata.
  - Beat counter and starvation counter cleared.
  - An in-flight read is discarded; no rvalid follows the clear.
  - Reset mid-burst aborts the burst silently, with no dma_done.
- FSM states: IDLE, BURST, DONE.
  - IDLE: the CPU owns every cycle. On dma_start: latch base, len and we, clear the beat counter, go to BURST. dma_start is ignored in BURST/DONE.
  - BURST: arbitrate every cycle (rules below). When the DMA issues beat number len, go to DONE.
  - DONE: one cycle. dma_done = 1; the last read's dma_rvalid coincides with this cycle. CPU is still served. Next state is IDLE.
- Arbitration in BURST:
  - CPU wins if cpu_req is high (and, with the guard, starve_cnt < STARVE_MAX); starve_cnt then increments.
  - Otherwise DMA wins and starve_cnt clears.
  - Without cpu_req, DMA always wins.
- Grant effects:
  - cpu_stall = cpu_req & ~cpu_grant (combinational). It is 0 whenever cpu_req is 0.
  - DMA grant drives ram_addr = base + beat (mod 2^A_WIDTH), with ram_we = we and ram_re = ~we.
  - On a DMA write grant, dma_wready = 1 and ram_wdata = dma_wdata.
  - The beat counter increments on every DMA grant.
- No grant: ram_we = ram_re = 0; ram_addr and ram_wdata hold the CPU values.
- Read return:
  - A one-bit owner tag registers with ram_re.
  - The next cycle, ram_rdata is captured into cpu_rdata or dma_rdata, and the matching rvalid pulses for 1 cycle.
  - Latency is 1 cycle from grant to rvalid.
- Writes complete at the granting edge. No response is generated.
- Simultaneous CPU and DMA on the same address:
  - Only one is granted per cycle, so there is no conflict.
  - The order is the grant order.

Optional Feature:
- ARB_STARVE_GUARD_EN
- Defined: the STARVE_MAX rule applies, so the DMA is guaranteed at least one beat per STARVE_MAX+1 cycles under continuous cpu_req.
- Undefined: the CPU has strict priority, the starvation counter is absent, and the DMA may wait indefinitely. All other behaviour is identical.

Test Plan:
- Reset mid-burst:
  - Stimulus: g_clr for 1 cycle during a 4-beat read burst with a read in flight.
  - Required response: next cycle dma_busy=0, dma_rvalid=0, dma_done never pulses; a subsequent dma_start is accepted.
- DMA write, then CPU read:
  - Stimulus: dma_start, we=1, base=8'hFE, len=3, no cpu_req.
  - Required response:
    - dma_wready high for 4 consecutive cycles; RAM writes go to FE, FF, 00, 01 (wrap).
    - dma_done pulses on the cycle after the 4th beat; dma_busy drops one cycle later.
    - CPU read of 8'h00 then returns the written beat 3 with cpu_rvalid exactly 1 cycle after the grant.
- DMA read burst, idle CPU:
  - Stimulus: we=0, base=8'h10, len=1.
  - Required response: dma_rvalid pulses twice with the contents of 10 and 11; the second pulse coincides with dma_done.
- CPU priority:
  - Stimulus: dma burst len=0; cpu_req held 2 cycles.
  - Required response: cpu_stall=0 both cycles; the DMA beat is granted on the 3rd cycle.
- Guard, STARVE_MAX=3, continuous cpu_req:
  - Stimulus: dma len=1.
  - Required response:
    - With guard: the CPU wins 3 cycles, then cpu_stall=1 for 1 cycle (DMA beat), then the CPU wins 3 cycles, then the DMA wins.
    - Without guard: cpu_stall never asserts and dma_busy stays 1.
- Ignored start:
  - Stimulus: dma_start during BURST with a different base.
  - Required response: no effect; addresses continue from the original base.
